// File: rtl/snes_clk_rst_ctrl.sv
// PLL-lock qualification, system reset sequencing and master-clock enable
// generation for the single-clock SNES core on Primer25K.
module snes_clk_rst_ctrl #(
  parameter int CE_DIV      = 6,
  parameter int LOCK_STABLE = 1024,
  parameter int RESET_HOLD  = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       soft_reset,
  output logic       sys_resetn,
  output logic       pll_ready,
  output logic       mclk_ce,
  output logic [2:0] phase,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;

  localparam logic [2:0]  PHASE_LAST  = 3'(CE_DIV - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(RESET_HOLD - 1);

  state_t                 state, state_nxt;
  logic [15:0]            cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  logic                   loss_inc;
  logic [2:0]             phase_nxt;

  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign phase_nxt = (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;

  // NOTE: every output defaults first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_inc  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = 16'd0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = 16'd0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      HOLD: begin
        // Leaving only at the last phase makes sys_resetn rise with phase 0.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = 16'd0;
        end else if (cnt >= HOLD_LAST && phase == PHASE_LAST) begin
          state_nxt = RUN;
        end else if (cnt != 16'hFFFF) begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          loss_inc  = 1'b1;
        end else if (soft_reset) begin
          state_nxt = HOLD;
          cnt_nxt   = 16'd0;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= WAIT_LOCK;
      cnt           <= 16'd0;
      lock_sync     <= '0;
      phase         <= 3'd0;
      mclk_ce       <= 1'b0;
      sys_resetn    <= 1'b0;
      pll_ready     <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lock_sync  <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
      phase      <= phase_nxt;
      mclk_ce    <= (phase_nxt == 3'd0);
      sys_resetn <= (state_nxt == RUN);
      pll_ready  <= (state_nxt == HOLD) || (state_nxt == RUN);
      if (loss_inc && lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_snes_clk_rst_ctrl.sv
// Directed bench for snes_clk_rst_ctrl: a vector table for the post-reset
// phase/enable sequence plus hand-timed sequences for lock, soft reset and reset.
module tb_snes_clk_rst_ctrl;

  localparam int CE_DIV = 6;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       soft_reset;
  logic       sys_resetn;
  logic       pll_ready;
  logic       mclk_ce;
  logic [2:0] phase;
  logic [7:0] lock_loss_cnt;

  int checks_total  = 0;
  int checks_passed = 0;
  int edge_n        = 0;
  int bad_cycles    = 0;

  typedef struct {
    logic lock;
    int   ph;
    logic ce;
    logic rdy;
    logic sysr;
  } vec_t;

  vec_t vecs[8];

  snes_clk_rst_ctrl #(
    .CE_DIV(6), .LOCK_STABLE(16), .RESET_HOLD(8), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .soft_reset(soft_reset),
    .sys_resetn(sys_resetn), .pll_ready(pll_ready), .mclk_ce(mclk_ce),
    .phase(phase), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  // One clock edge, sampled 1 ns later; phase and mclk_ce are tracked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (int'(phase) != edge_n % CE_DIV || mclk_ce != (edge_n % CE_DIV == 0))
      bad_cycles++;
  endtask

  function automatic int next_aligned(input int e);
    int k = e;
    while (k % CE_DIV != 0) k++;
    return k;
  endfunction

  function automatic logic hit(input int which);
    case (which)
      0:       return pll_ready;
      1:       return sys_resetn;
      default: return !sys_resetn;
    endcase
  endfunction

  // which: 0 = pll_ready high, 1 = sys_resetn high, 2 = sys_resetn low.
  task automatic run_until(input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (hit(which)) begin
        at = edge_n;
        break;
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    int at, rdy_at, sr_at, exp_cnt;

    vecs[0] = '{1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 5, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 2, 1'b0, 1'b0, 1'b0};

    resetn = 1'b0; pll_lock = 1'b0; soft_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sys_resetn", sys_resetn, 0);
    check("rst_pll_ready", pll_ready, 0);
    check("rst_mclk_ce", mclk_ce, 0);
    check("rst_phase", phase, 0);
    check("rst_lock_loss_cnt", lock_loss_cnt, 0);
    release_reset();

    foreach (vecs[i]) begin
      pll_lock = vecs[i].lock;
      tick();
      check($sformatf("vec%0d_phase", i), phase, vecs[i].ph);
      check($sformatf("vec%0d_mclk_ce", i), mclk_ce, vecs[i].ce);
      check($sformatf("vec%0d_pll_ready", i), pll_ready, vecs[i].rdy);
      check($sformatf("vec%0d_sys_resetn", i), sys_resetn, vecs[i].sysr);
    end

    // Steady lock: first sampled at edge 9 -> ready at 27, release at 36.
    pll_lock = 1'b1;
    run_until(0, 40, rdy_at);
    check("t1_ready_edge", rdy_at, 27);
    check("t1_sysr_low_at_ready", sys_resetn, 0);
    run_until(1, 30, at);
    check("t1_sysr_edge", at, next_aligned(rdy_at + 8));
    check("t1_sysr_phase", phase, 0);
    check("t1_sysr_mclk_ce", mclk_ce, 1);
    check("t1_ce_period", bad_cycles, 0);

    // Restart with lock already high; one synchronized low cycle at STABLE cnt=10.
    @(posedge clk);
    #1;
    resetn = 1'b0;
    release_reset();
    pll_lock = 1'b1;
    repeat (11) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    run_until(0, 40, rdy_at);
    check("t2_ready_edge", rdy_at, 31);
    check("t2_sysr_low_at_ready", sys_resetn, 0);
    check("t2_loss_cnt", lock_loss_cnt, 0);
    run_until(1, 30, at);
    check("t2_sysr_edge", at, 42);

    // Soft reset at phase 3.
    while (edge_n % CE_DIV != 3) tick();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    sr_at = edge_n;
    check("t3_sysr_low", sys_resetn, 0);
    check("t3_ready_kept", pll_ready, 1);
    run_until(1, 30, at);
    check("t3_sysr_edge", at, next_aligned(sr_at + 8));
    check("t3_sysr_phase", phase, 0);
    check("t3_ready_at_rise", pll_ready, 1);

    // Lock loss in RUN: sys_resetn low three edges after the drop.
    pll_lock = 1'b0;
    sr_at = edge_n;
    run_until(2, 10, at);
    check("t4_drop_latency", at - sr_at, 3);
    check("t4_ready_low", pll_ready, 0);
    check("t4_loss_cnt", lock_loss_cnt, 1);

    // Lock loss and soft reset seen in the same RUN cycle.
    pll_lock = 1'b1;
    run_until(1, 80, at);
    check("t5_run_reached", sys_resetn, 1);
    pll_lock = 1'b0;
    tick();
    tick();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check("t5_sysr_low", sys_resetn, 0);
    check("t5_ready_low", pll_ready, 0);
    check("t5_loss_cnt", lock_loss_cnt, 2);

    // Drive the loss counter into saturation.
    for (int n = 3; n <= 300; n++) begin
      pll_lock = 1'b1;
      run_until(1, 80, at);
      if (at < 0) check($sformatf("t4_run_%0d", n), at, 0);
      pll_lock = 1'b0;
      run_until(2, 10, at);
      exp_cnt = (n > 255) ? 255 : n;
      check($sformatf("t4_loss_cnt_%0d", n), lock_loss_cnt, exp_cnt);
    end
    check("t4_ce_period", bad_cycles, 0);

    // Asynchronous reset in the middle of HOLD.
    pll_lock = 1'b1;
    run_until(0, 40, at);
    check("t6_in_hold", pll_ready, 1);
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check("t6_sys_resetn", sys_resetn, 0);
    check("t6_pll_ready", pll_ready, 0);
    check("t6_mclk_ce", mclk_ce, 0);
    check("t6_phase", phase, 0);
    check("t6_loss_cnt", lock_loss_cnt, 0);
    release_reset();
    bad_cycles = 0;
    run_until(0, 40, rdy_at);
    check("t6_ready_edge", rdy_at, 19);
    run_until(1, 30, at);
    check("t6_sysr_edge", at, 30);
    check("t6_sysr_mclk_ce", mclk_ce, 1);
    check("t6_ce_period", bad_cycles, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
